// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: assembles a W-bit word MSB first, checks an
// optional even-parity bit and issues one write pulse per good frame.
module serial_word_loader #(
  parameter int W         = 16,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_asynchronous_n,
  input  logic         start_frame,
  input  logic         bit_valid,
  input  logic         serial_in,
  output logic [W-1:0] data_out,
  output logic         write_enable_out,
  output logic         parity_error,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   data_q, data_d;
  logic           we_q, we_d;
  logic           perr_q, perr_d;
  logic           busy_q, busy_d;

  // Even parity: the parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [W-1:0] word);
    return ^word;
  endfunction

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    data_d  = data_q;
    we_d    = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          shift_d = '0;
          count_d = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // start_frame wins over a coincident bit, which is dropped.
        if (start_frame) begin
          shift_d = '0;
          count_d = '0;
          state_d = SHIFT;
        end else if (bit_valid) begin
          shift_d = {shift_q[W-2:0], serial_in};
          count_d = count_q + CW'(1);
          if (count_q == CW'(W - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              data_d  = {shift_q[W-2:0], serial_in};
              we_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      PARITY: begin
        if (start_frame) begin
          shift_d = '0;
          count_d = '0;
          state_d = SHIFT;
        end else if (bit_valid) begin
          if (serial_in == even_parity(shift_q)) begin
            data_d = shift_q;
            we_d   = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          state_d = PARITY;
        end
      end
      default: begin
        shift_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
      we_q    <= we_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out         = data_q;
  assign write_enable_out = we_q;
  assign parity_error     = perr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: directed frame table, abort/reset sequences,
// randomized frames against a parity model, and a no-parity instance.
module tb_serial_word_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0, bv = 1'b0, si = 1'b0;
  logic [15:0] dout;
  logic        we, perr, busy;
  logic        st0 = 1'b0, bv0 = 1'b0, si0 = 1'b0;
  logic [15:0] dout0;
  logic        we0, perr0, busy0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_word_loader #(.W(16), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset_asynchronous_n(rst_n), .start_frame(st), .bit_valid(bv),
    .serial_in(si), .data_out(dout), .write_enable_out(we), .parity_error(perr),
    .busy(busy));

  serial_word_loader #(.W(16), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset_asynchronous_n(rst_n), .start_frame(st0), .bit_valid(bv0),
    .serial_in(si0), .data_out(dout0), .write_enable_out(we0), .parity_error(perr0),
    .busy(busy0));

  typedef struct {
    logic [15:0] word;
    logic        par;
    int          gap;
    logic        exp_we;
    logic        exp_pe;
    logic [15:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bits shifted with no start pulse; counts any pulse seen meanwhile.
  task automatic send_bits(input logic [15:0] w, input int n, output int stray);
    stray = 0;
    for (int i = 15; i > 15 - n; i--) begin
      bv = 1'b1; si = w[i];
      step();
      bv = 1'b0;
      if (we || perr) stray++;
    end
  endtask

  // Full frame on the parity instance; bv/si may be preset by the caller.
  task automatic send_frame(input logic [15:0] w, input logic p, input int gap,
                            output logic we_s, output logic pe_s, output int stray,
                            output logic busy_mid, output logic busy_end);
    stray = 0;
    st = 1'b1;
    step();
    st = 1'b0; bv = 1'b0;
    busy_mid = busy;
    if (we || perr) stray++;
    for (int i = 15; i >= 0; i--) begin
      bv = 1'b1; si = w[i];
      step();
      bv = 1'b0;
      if (we || perr) stray++;
      repeat (gap) begin
        step();
        if (we || perr) stray++;
      end
    end
    bv = 1'b1; si = p;
    step();
    bv = 1'b0;
    we_s = we; pe_s = perr; busy_end = busy;
  endtask

  vec_t        tbl[6];
  logic        we_s, pe_s, bm, be;
  int          stray;
  logic [15:0] exp_data;
  logic [15:0] w;
  logic        p, good;
  int          t_first, t_second, pe0_seen;

  initial begin
    tbl[0] = '{16'hA5C3, 1'b1, 0, 1'b0, 1'b1, 16'h0000};
    tbl[1] = '{16'hA5C3, 1'b0, 0, 1'b1, 1'b0, 16'hA5C3};
    tbl[2] = '{16'h0001, 1'b1, 3, 1'b1, 1'b0, 16'h0001};
    tbl[3] = '{16'h8000, 1'b0, 1, 1'b0, 1'b1, 16'h0001};
    tbl[4] = '{16'h0000, 1'b0, 0, 1'b1, 1'b0, 16'h0000};
    tbl[5] = '{16'hFFFF, 1'b0, 2, 1'b1, 1'b0, 16'hFFFF};

    step();
    step();
    check("reset data_out", dout, 16'h0000);
    check("reset write_enable", we, 1'b0);
    check("reset parity_error", perr, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset np data_out", dout0, 16'h0000);
    #2 rst_n = 1'b1;
    step();

    // bit_valid while idle must be ignored.
    bv = 1'b1; si = 1'b1;
    repeat (3) step();
    bv = 1'b0;
    check("idle ignores bits busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].word, tbl[i].par, tbl[i].gap, we_s, pe_s, stray, bm, be);
      check($sformatf("tbl%0d we", i), we_s, tbl[i].exp_we);
      check($sformatf("tbl%0d perr", i), pe_s, tbl[i].exp_pe);
      check($sformatf("tbl%0d data", i), dout, tbl[i].exp_data);
      check($sformatf("tbl%0d stray", i), stray, 0);
      check($sformatf("tbl%0d busy mid", i), bm, 1'b1);
      check($sformatf("tbl%0d busy end", i), be, 1'b0);
      step();
      check($sformatf("tbl%0d pulse one cycle", i), {we, perr}, 2'b00);
    end

    // Abort after 9 bits; restart coincides with a valid bit that is dropped.
    st = 1'b1; step(); st = 1'b0;
    send_bits(16'hFFFF, 9, stray);
    check("abort partial stray", stray, 0);
    bv = 1'b1; si = 1'b1;
    send_frame(16'h1234, 1'b1, 0, we_s, pe_s, stray, bm, be);
    check("abort we", we_s, 1'b1);
    check("abort perr", pe_s, 1'b0);
    check("abort data", dout, 16'h1234);
    check("abort stray", stray, 0);
    step();
    check("abort single pulse", {we, perr}, 2'b00);

    // Asynchronous reset in the middle of a frame, between edges.
    st = 1'b1; step(); st = 1'b0;
    send_bits(16'hABCD, 5, stray);
    #2 rst_n = 1'b0;
    #1;
    check("async rst data", dout, 16'h0000);
    check("async rst busy", busy, 1'b0);
    check("async rst pulses", {we, perr}, 2'b00);
    #2 rst_n = 1'b1;
    step();
    send_frame(16'hFFFF, 1'b0, 0, we_s, pe_s, stray, bm, be);
    check("post rst we", we_s, 1'b1);
    check("post rst data", dout, 16'hFFFF);
    exp_data = 16'hFFFF;

    // Random frames against the parity model; some are aborted part-way.
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom());
      good = ($urandom_range(0, 3) != 0);
      p = good ? (($countones(w) % 2) == 1) : (($countones(w) % 2) == 0);
      if ($urandom_range(0, 4) == 0) begin
        st = 1'b1; step(); st = 1'b0;
        send_bits(16'($urandom()), $urandom_range(1, 16), stray);
        check("rand abort stray", stray, 0);
        bv = 1'b1; si = 1'($urandom());
      end
      send_frame(w, p, $urandom_range(0, 2), we_s, pe_s, stray, bm, be);
      if (good) exp_data = w;
      check("rand we", we_s, good);
      check("rand perr", pe_s, !good);
      check("rand data", dout, exp_data);
      check("rand stray", stray, 0);
    end
    step();

    // No-parity instance: back-to-back frames, second starts in the pulse cycle.
    pe0_seen = 0;
    t_first = 0;
    t_second = 0;
    st0 = 1'b1; step(); st0 = 1'b0;
    w = 16'h8001;
    for (int i = 15; i >= 0; i--) begin
      bv0 = 1'b1; si0 = w[i]; step(); bv0 = 1'b0;
      if (perr0) pe0_seen++;
    end
    check("np frame1 we", we0, 1'b1);
    check("np frame1 data", dout0, 16'h8001);
    t_first = cyc;
    st0 = 1'b1; step(); st0 = 1'b0;
    check("np frame1 single pulse", we0, 1'b0);
    w = 16'h7FFE;
    for (int i = 15; i >= 0; i--) begin
      bv0 = 1'b1; si0 = w[i]; step(); bv0 = 1'b0;
      if (perr0) pe0_seen++;
      if (we0 && t_second == 0) t_second = cyc;
    end
    check("np frame2 we", we0, 1'b1);
    check("np frame2 data", dout0, 16'h7FFE);
    // One start cycle plus 16 bit cycles separate the two pulses.
    check("np pulse spacing", t_second - t_first, 17);
    check("np no parity error", pe0_seen, 0);
    step();
    check("np frame2 single pulse", we0, 1'b0);
    check("np idle busy", busy0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
